// File: rtl/dna_port_reader.sv
// Reads the 96-bit device ID out of a DNA port primitive. The primitive is clocked by a
// divided clock, and the ID is recirculated through DIN so the primitive keeps its value.
module dna_port_reader #(
    parameter int CLK_DIV    = 4,
    parameter bit AUTO_START = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        valid,
    output logic [95:0] dna_value,
    output logic        dna_clk,
    output logic        dna_read,
    output logic        dna_shift,
    output logic        dna_din,
    input  logic        dna_dout
);
    localparam int HALF    = CLK_DIV / 2;
    localparam int PHASE_W = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [PHASE_W-1:0] PHASE_LAST  = PHASE_W'(HALF - 1);
    localparam logic [6:0]         PERIOD_LAST = 7'd95;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOAD   = 2'd1;
    localparam logic [1:0] ST_SHIFT  = 2'd2;
    localparam logic [1:0] ST_FINISH = 2'd3;

    logic [1:0]         state_reg;
    logic [PHASE_W-1:0] phase_reg;
    logic [6:0]         period_reg;
    logic               dna_clk_reg;
    logic               read_reg;
    logic               shift_reg;
    logic               busy_reg;
    logic               done_reg;
    logic               valid_reg;
    logic               auto_pending_reg;
    logic [95:0]        cap_reg;
    logic [95:0]        value_reg;

    logic go;
    logic phase_end;
    logic rise_edge;
    logic period_end;

    // The auto-start request exists only on the first edge after reset release.
    assign go         = start | auto_pending_reg;
    assign phase_end  = (phase_reg == PHASE_LAST);
    assign rise_edge  = phase_end & ~dna_clk_reg;
    assign period_end = phase_end & dna_clk_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= ST_IDLE;
            phase_reg        <= '0;
            period_reg       <= '0;
            dna_clk_reg      <= 1'b0;
            read_reg         <= 1'b0;
            shift_reg        <= 1'b0;
            busy_reg         <= 1'b0;
            done_reg         <= 1'b0;
            valid_reg        <= 1'b0;
            auto_pending_reg <= AUTO_START;
            cap_reg          <= '0;
            value_reg        <= '0;
        end else begin
            auto_pending_reg <= 1'b0;
            done_reg         <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (go) begin
                        state_reg   <= ST_LOAD;
                        busy_reg    <= 1'b1;
                        read_reg    <= 1'b1;
                        shift_reg   <= 1'b0;
                        dna_clk_reg <= 1'b0;
                        phase_reg   <= '0;
                        period_reg  <= '0;
                    end
                end
                ST_LOAD, ST_SHIFT: begin
                    phase_reg <= phase_end ? '0 : phase_reg + 1'b1;
                    if (rise_edge) begin
                        dna_clk_reg <= 1'b1;
                        // DOUT is sampled before the primitive sees this rising edge.
                        if (state_reg == ST_SHIFT) begin
                            cap_reg <= {dna_dout, cap_reg[95:1]};
                        end
                    end else if (period_end) begin
                        dna_clk_reg <= 1'b0;
                        if (state_reg == ST_LOAD) begin
                            state_reg <= ST_SHIFT;
                            read_reg  <= 1'b0;
                            shift_reg <= 1'b1;
                        end else if (period_reg == PERIOD_LAST) begin
                            state_reg <= ST_FINISH;
                            shift_reg <= 1'b0;
                            done_reg  <= 1'b1;
                            valid_reg <= 1'b1;
                            value_reg <= cap_reg;
                        end else begin
                            period_reg <= period_reg + 7'd1;
                        end
                    end
                end
                ST_FINISH: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_reg;
    assign done      = done_reg;
    assign valid     = valid_reg;
    assign dna_value = value_reg;
    assign dna_clk   = dna_clk_reg;
    assign dna_read  = read_reg;
    assign dna_shift = shift_reg;
    assign dna_din   = dna_dout;

endmodule
